// File: rtl/vote_link_arbiter.sv
// vote_link_arbiter
//   Round-robin arbiter that shares one vote tally datapath among N_TERM
//   terminals. A terminal is granted (term_rtr), its 4-bit vote word is
//   captured on term_cts and parity-checked. Green/red tallies and the
//   parity-error and timeout counters are updated, then the terminal is
//   released once it drops cts.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset, clears all state
//   enable       permit new grants (an open transaction always completes)
//   clear_tally  synchronous clear of tallies and error counters (wins over increment)
//   req          per-terminal service request, sampled only in IDLE
//   term_cts     per-terminal clear-to-send
//   term_v       per-terminal vote word, terminal i at [4i+3:4i]
//   term_rtr     ready-to-receive, one-hot or zero
//   grant_id     current / last granted terminal
//   busy         FSM is not in IDLE
//   vote_valid   one-cycle pulse for an accepted vote on vote_data
//   vote_data    last captured vote word
//   tally_g/r    accepted votes with bit1 / bit2 set, saturating
//   err_count    parity failures, saturating at 15
//   to_count     handshake timeouts, saturating at 15
module vote_link_arbiter #(
    parameter int N_TERM  = 4,
    parameter int TIMEOUT = 15,
    parameter int TALLY_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_tally,
    input  logic [N_TERM-1:0]     req,
    input  logic [N_TERM-1:0]     term_cts,
    input  logic [4*N_TERM-1:0]   term_v,
    output logic [N_TERM-1:0]     term_rtr,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  vote_valid,
    output logic [3:0]            vote_data,
    output logic [TALLY_W-1:0]    tally_g,
    output logic [TALLY_W-1:0]    tally_r,
    output logic [3:0]            err_count,
    output logic [3:0]            to_count
);

    typedef enum logic [2:0] {IDLE, GRANT, CHECK, RELEASE, ADVANCE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        ptr;
    logic [7:0]        wait_cnt;
    logic              sel_cts;
    logic [3:0]        sel_v;
    logic [2:0]        pick_id;
    logic [2:0]        rtr_id;
    logic [N_TERM-1:0] rtr_nxt;
    logic              wait_exp;
    logic              par_ok;
    logic              to_inc, err_inc, g_inc, r_inc;

    // Mux the granted terminal's cts and vote word.
    always_comb begin
        sel_cts = 1'b0;
        sel_v   = 4'd0;
        for (int i = 0; i < N_TERM; i++) begin
            if (grant_id == 3'(i)) begin
                sel_cts = term_cts[i];
                sel_v   = term_v[4*i +: 4];
            end
        end
    end

    // Round-robin pick: the requester with the smallest wrapped distance
    // from the pointer wins.
    always_comb begin
        int best;
        int d;
        best    = N_TERM;
        pick_id = ptr;
        for (int i = 0; i < N_TERM; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + N_TERM;
            if (req[i] && d < best) begin
                best    = d;
                pick_id = 3'(i);
            end
        end
    end

    assign wait_exp = (wait_cnt == 8'(TIMEOUT - 1));
    assign par_ok   = (vote_data[3] == ^vote_data[2:0]);

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && req != '0) state_nxt = GRANT;
            GRANT:   if (sel_cts)             state_nxt = CHECK;
                     else if (wait_exp)       state_nxt = RELEASE;
            CHECK:                            state_nxt = RELEASE;
            RELEASE: if (!sel_cts || wait_exp) state_nxt = ADVANCE;
            ADVANCE:                          state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // rtr is registered from the next state; on the IDLE->GRANT edge the
    // new grant id is not yet in grant_id, so use the pick directly.
    always_comb begin
        rtr_id  = (state == IDLE) ? pick_id : grant_id;
        rtr_nxt = '0;
        for (int i = 0; i < N_TERM; i++)
            rtr_nxt[i] = (state_nxt == GRANT || state_nxt == CHECK) && (rtr_id == 3'(i));
    end

    // Counter increment requests
    always_comb begin
        to_inc  = (state == GRANT   && !sel_cts && wait_exp) ||
                  (state == RELEASE &&  sel_cts && wait_exp);
        err_inc = (state == CHECK) && !par_ok;
        g_inc   = (state == CHECK) &&  par_ok && vote_data[1];
        r_inc   = (state == CHECK) &&  par_ok && vote_data[2];
    end

    // Transaction datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            term_rtr   <= '0;
            grant_id   <= 3'd0;
            busy       <= 1'b0;
            vote_valid <= 1'b0;
            vote_data  <= 4'd0;
            ptr        <= 3'd0;
            wait_cnt   <= 8'd0;
        end else begin
            term_rtr   <= rtr_nxt;
            busy       <= (state_nxt != IDLE);
            vote_valid <= (state == CHECK) && par_ok;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (state_nxt == GRANT) grant_id <= pick_id;
                end
                GRANT: begin
                    if (sel_cts)        vote_data <= sel_v;
                    else if (!wait_exp) wait_cnt  <= wait_cnt + 8'd1;
                end
                CHECK:   wait_cnt <= 8'd0;
                RELEASE: if (sel_cts && !wait_exp) wait_cnt <= wait_cnt + 8'd1;
                ADVANCE: ptr <= (grant_id == 3'(N_TERM - 1)) ? 3'd0 : grant_id + 3'd1;
                default: ;
            endcase
        end
    end

    // Saturating counters; clear_tally takes priority over any increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tally_g   <= '0;
            tally_r   <= '0;
            err_count <= 4'd0;
            to_count  <= 4'd0;
        end else if (clear_tally) begin
            tally_g   <= '0;
            tally_r   <= '0;
            err_count <= 4'd0;
            to_count  <= 4'd0;
        end else begin
            if (g_inc   && !(&tally_g))   tally_g   <= tally_g + TALLY_W'(1);
            if (r_inc   && !(&tally_r))   tally_r   <= tally_r + TALLY_W'(1);
            if (err_inc && !(&err_count)) err_count <= err_count + 4'd1;
            if (to_inc  && !(&to_count))  to_count  <= to_count + 4'd1;
        end
    end

endmodule
